// File: rtl/element_divmod_seq.sv
// Sequential element-wise unsigned divide/modulo over a WIDTH x WIDTH matrix of 32-bit words.
// Optional per-element divide-by-zero flag output enabled by `define ELEM_DIVMOD_DZ_FLAG_EN.

`ifndef WIDTH_BIT
`define WIDTH_BIT 1
`endif

module element_divmod_seq #(
    parameter int WIDTH = 2 ** `WIDTH_BIT
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [0:WIDTH-1][0:WIDTH-1][31:0]    a,
    input  logic [0:WIDTH-1][0:WIDTH-1][31:0]    b,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [0:WIDTH-1][0:WIDTH-1][31:0]    quotient,
    output logic [0:WIDTH-1][0:WIDTH-1][31:0]    remainder
`ifdef ELEM_DIVMOD_DZ_FLAG_EN
    ,
    output logic [0:WIDTH-1][0:WIDTH-1]          dz_flag
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [0:WIDTH-1][0:WIDTH-1][31:0] mat_t;
    typedef logic [0:WIDTH-1][0:WIDTH-1][32:0] mat33_t;

    state_t state;
    state_t state_nx;
    logic [4:0] cnt;

    mat_t   dvd_q;
    mat_t   dvs_q;
    mat_t   rem_q;
    mat_t   quo_q;
    mat_t   dvd_nx;
    mat_t   rem_nx;
    mat_t   quo_nx;
    mat33_t rem_sh;

    logic last_iter;
    assign last_iter = (state == BUSY) && (cnt == 5'd31);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = BUSY;
            BUSY:    if (last_iter) state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // One restoring-division step for every element in parallel. The
    // 33-bit shifted remainder is compared against the zero-extended
    // divisor; when it subtracts, the true difference is below the divisor
    // and so fits in 32 bits, which lets the subtraction stay 32 bits wide.
    // A zero divisor always subtracts, yielding all-ones and remainder = a.
    // ------------------------------------------------------------------
    always_comb begin
        rem_sh = '0;
        rem_nx = rem_q;
        quo_nx = quo_q;
        dvd_nx = dvd_q;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                rem_sh[i][j] = {rem_q[i][j], dvd_q[i][j][31]};
                dvd_nx[i][j] = {dvd_q[i][j][30:0], 1'b0};
                if (rem_sh[i][j] >= {1'b0, dvs_q[i][j]}) begin
                    rem_nx[i][j] = rem_sh[i][j][31:0] - dvs_q[i][j];
                    quo_nx[i][j] = {quo_q[i][j][30:0], 1'b1};
                end else begin
                    rem_nx[i][j] = rem_sh[i][j][31:0];
                    quo_nx[i][j] = {quo_q[i][j][30:0], 1'b0};
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    // NOTE: the operand and result registers are reset as well, so the
    // outputs read zero from reset and no stale partial result survives it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 5'd0;
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        dvd_q <= a;
                        dvs_q <= b;
                        rem_q <= '0;
                        quo_q <= '0;
                        cnt   <= 5'd0;
                    end
                end
                BUSY: begin
                    dvd_q <= dvd_nx;
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    if (!last_iter) begin
                        cnt <= cnt + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ELEM_DIVMOD_DZ_FLAG_EN
    logic [0:WIDTH-1][0:WIDTH-1] dz_cap;

    always_comb begin
        dz_cap = '0;
        for (int i = 0; i < WIDTH; i++) begin
            for (int j = 0; j < WIDTH; j++) begin
                dz_cap[i][j] = (b[i][j] == 32'd0);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_flag <= '0;
        end else if (state == IDLE && in_valid) begin
            dz_flag <= dz_cap;
        end
    end
`endif

    // Results are read straight from the working registers; they only carry
    // meaning while out_valid is high and are held untouched in DONE/IDLE.
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: doc/element_divmod_seq.md
Name: element_divmod_seq

Overview:
- Sequential, handshaked element-wise unsigned divider over a WIDTH x WIDTH matrix of 32-bit words.
- Computes quotient and remainder for every element in one operation, undoing an element-wise multiply.
- Replaces the single-cycle "/" and "%" matrix operators on timing-critical paths.
- Sits between the matrix register file and the writeback stage.
- All elements run in parallel, radix-2 restoring division, 32 iterations per operation.

Parameters:
- WIDTH, 2 ** `WIDTH_BIT (from CONSTANT.v), matrix side length; matrix has WIDTH*WIDTH elements of 32 bits.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand matrices a and b are valid.
- in_ready  output  1  block can accept an operation.
- a  input  [0:WIDTH-1][0:WIDTH-1][31:0]  dividend matrix.
- b  input  [0:WIDTH-1][0:WIDTH-1][31:0]  divisor matrix.
- out_valid  output  1  quotient and remainder are valid.
- out_ready  input  1  consumer accepts the result.
- quotient  output  [0:WIDTH-1][0:WIDTH-1][31:0]  per-element a/b.
- remainder  output  [0:WIDTH-1][0:WIDTH-1][31:0]  per-element a%b.

Behaviour:
- Reset:
  - rst_n low asynchronously forces state IDLE, iteration counter 0, out_valid 0, quotient and remainder all zero.
  - in_ready reads 1 as soon as rst_n is high.
  - Reset in any state discards the in-flight operation; no partial result is ever presented.
- FSM has three states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
- IDLE:
  - On a clk edge with in_valid=1, latch a and b into internal registers.
  - Clear partial remainders (33 bits each) and quotient shift registers.
  - Set counter=0 and go to BUSY.
  - a and b may change freely after acceptance.
- BUSY, one iteration per cycle, all elements in parallel:
  - rem = {rem[31:0], dividend_msb}.
  - Shift the dividend left by 1.
  - If rem >= {1'b0, b}: rem = rem - b and the quotient bit is 1; otherwise the quotient bit is 0.
  - Shift the quotient bit into the LSB of the quotient.
  - When counter==31, the iteration completes and the state goes to DONE; otherwise counter increments.
- Latency:
  - An accept at edge E0 gives out_valid=1 after edge E32, i.e. exactly 32 cycles.
  - Throughput is at most one operation per 33 cycles.
- DONE:
  - quotient and remainder are held stable while out_valid=1 and out_ready=0, for an unbounded time.
  - On an edge with out_ready=1: go to IDLE and drop out_valid. quotient and remainder keep their last values, but consumers must not sample them without out_valid.
  - in_ready is 0 in DONE, so there is no same-cycle result-drain plus new-accept.
- Arithmetic:
  - Unsigned 32-bit.
  - Internal remainder is 33 bits; remainder output is the low 32 bits and is always < b when b != 0.
- Divide by zero, per element, a natural result of the algorithm:
  - quotient = 32'hFFFF_FFFF.
  - remainder = a.
  - No stall, no effect on other elements.
- in_valid asserted while in BUSY or DONE is ignored. The source must hold it until it sees in_ready.

Optional Feature:
- Macro: ELEM_DIVMOD_DZ_FLAG_EN.
- Defined:
  - Adds output port dz_flag [0:WIDTH-1][0:WIDTH-1] (1 bit per element).
  - Each bit is captured at acceptance as (b[i][j]==0).
  - Valid when out_valid=1; reset value 0; held with the result.
- Undefined: the port and its registers are absent. All other behaviour is identical.

Test Plan (bench WIDTH=2):
1. Basic:
   - Stimulus: a={100,7,0,32'hFFFF_FFFF}, b={7,100,5,1}, accepted at E0, out_ready=1.
   - Response: out_valid rises after E32; quotient={14,0,0,32'hFFFF_FFFF}, remainder={2,7,0,0}.
2. Divide by zero:
   - Stimulus: a={13,0,5,9}, b={0,0,5,3}.
   - Response: quotient={FFFF_FFFF,FFFF_FFFF,1,3}, remainder={13,0,0,0}.
   - With ELEM_DIVMOD_DZ_FLAG_EN: dz_flag={1,1,0,0}.
3. Back-pressure:
   - Stimulus: hold out_ready=0 for 10 cycles after out_valid; change a/b and pulse in_valid meanwhile.
   - Response: result is stable, in_ready=0, the new op is not accepted. After out_ready=1, in_ready returns 1 the next cycle.
4. Reset mid-op:
   - Stimulus: assert rst_n=0 at cycle 15 of BUSY.
   - Response: out_valid=0 and quotient/remainder=0 immediately (asynchronous); after release in_ready=1. A new op yields correct results with 32-cycle latency.
5. Large operands:
   - Stimulus: a=32'hFFFF_FFFF, b=32'h8000_0001 in every element.
   - Response: quotient=1, remainder=32'h7FFF_FFFE. This checks 33-bit remainder compare correctness.
6. Random:
   - Stimulus: 500 random unsigned operations with random out_ready stalls.
   - Response: every element matches a/b and a%b; latency is exactly 32 cycles from accept to out_valid.
